// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the unified memory port arbiter.
// master = arbiter view, slave = pipeline/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) ();
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              d_req;
    logic              d_wr;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              bus_err;
    logic              mem_en;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_ready,
        output i_rdata, i_done, d_rdata, d_done, bus_err,
        output mem_en, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_ready,
        input  i_rdata, i_done, d_rdata, d_done, bus_err,
        input  mem_en, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for the single-port unified memory: IDLE -> BUSY -> RESP sequencing.
// Optional macro ARB_ROUND_ROBIN_EN swaps data-priority/starvation grant for alternating grant.
module mem_port_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int MAX_STARVE = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.master bus
);

    localparam int TO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_owner_d;
    logic              r_mem_en;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_i_rdata;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_i_done;
    logic              r_d_done;
    logic              r_bus_err;
    logic [TO_W-1:0]   r_to_cnt;
`ifdef ARB_ROUND_ROBIN_EN
    logic              r_last_d;
`else
    logic [3:0]        r_starve_cnt;
`endif

    logic              w_any;
    logic              w_grant_d;
    logic              w_to_hit;

    // Grant decision for the current IDLE cycle and timeout detection in BUSY
    always_comb begin
        w_any     = bus.i_req | bus.d_req;
        w_grant_d = 1'b0;
        if (bus.d_req && bus.i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
            w_grant_d = ~r_last_d;
`else
            w_grant_d = (r_starve_cnt != 4'(MAX_STARVE));
`endif
        end else begin
            w_grant_d = bus.d_req;
        end
        w_to_hit = (r_to_cnt == TO_W'(TIMEOUT - 1));
    end

    // Transaction sequencer with registered memory strobes, read data and done pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_owner_d   <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_i_done    <= 1'b0;
            r_d_done    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_to_cnt    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_d    <= 1'b0;
`else
            r_starve_cnt <= 4'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_i_done  <= 1'b0;
                    r_d_done  <= 1'b0;
                    r_bus_err <= 1'b0;
                    if (w_any) begin
                        r_state     <= S_BUSY;
                        r_owner_d   <= w_grant_d;
                        r_mem_en    <= 1'b1;
                        r_mem_wr    <= w_grant_d & bus.d_wr;
                        r_mem_addr  <= w_grant_d ? bus.d_addr : bus.i_addr;
                        r_mem_wdata <= w_grant_d ? bus.d_wdata : '0;
                        r_to_cnt    <= '0;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_d    <= w_grant_d;
`else
                        // Only D grants taken over a waiting fetch count toward starvation
                        if (w_grant_d) begin
                            if (bus.i_req && (r_starve_cnt != 4'(MAX_STARVE))) begin
                                r_starve_cnt <= r_starve_cnt + 4'd1;
                            end
                        end else begin
                            r_starve_cnt <= 4'd0;
                        end
`endif
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ready) begin
                        if (!r_owner_d) begin
                            r_i_rdata <= bus.mem_rdata;
                        end else if (!r_mem_wr) begin
                            r_d_rdata <= bus.mem_rdata;
                        end
                        r_state   <= S_RESP;
                        r_mem_en  <= 1'b0;
                        r_mem_wr  <= 1'b0;
                        r_i_done  <= ~r_owner_d;
                        r_d_done  <= r_owner_d;
                        r_bus_err <= 1'b0;
                    end else if (w_to_hit) begin
                        r_state   <= S_RESP;
                        r_mem_en  <= 1'b0;
                        r_mem_wr  <= 1'b0;
                        r_i_done  <= ~r_owner_d;
                        r_d_done  <= r_owner_d;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_to_cnt  <= r_to_cnt + TO_W'(1);
                    end
                end
                S_RESP: begin
                    r_i_done  <= 1'b0;
                    r_d_done  <= 1'b0;
                    r_bus_err <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_mem_en  <= 1'b0;
                    r_mem_wr  <= 1'b0;
                    r_i_done  <= 1'b0;
                    r_d_done  <= 1'b0;
                    r_bus_err <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_en    = r_mem_en;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_rdata   = r_d_rdata;
    assign bus.i_done    = r_i_done;
    assign bus.d_done    = r_d_done;
    assign bus.bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected transactions are queued in grant order
// when requests are launched and compared as the memory bus and done pulses appear.
module tb_mem_port_arbiter;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int MAX_STARVE = 4;
    localparam int TIMEOUT    = 64;

    typedef struct {
        logic        is_d;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        err;
        int          busy;
    } exp_t;

    logic clk;
    logic rst;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_STARVE(MAX_STARVE), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int          n_checks;
    int          n_fail;
    exp_t        sb[$];
    int          lat;
    logic        noise;
    logic [15:0] i_base, d_base, w_base;
    logic        d_wr_mode;
    int          i_k, d_k, i_left, d_left;
    int          m_starve;
    logic        m_last_d;
    logic [15:0] exp_i_rd, exp_d_rd;
    logic        prev_en;
    int          busy_len;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        logic [15:0] beef;
        beef = 16'hBEEF;
        if (a == 16'h0010) return beef;
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] i_addr_of(input int k);
        return i_base + 16'(k * 2);
    endfunction

    function automatic logic [15:0] d_addr_of(input int k);
        return d_base + 16'(k * 2);
    endfunction

    function automatic logic [15:0] d_wdata_of(input int k);
        return w_base + 16'(k);
    endfunction

    // Expected grant order for n_i fetches and n_d data accesses, each side held until done
    function automatic void plan(input int n_i, input int n_d);
        int   ki;
        int   kd;
        logic gd;
        exp_t e;
        ki = 0;
        kd = 0;
        while (ki < n_i || kd < n_d) begin
            if (ki < n_i && kd < n_d) begin
`ifdef ARB_ROUND_ROBIN_EN
                gd = !m_last_d;
`else
                gd = (m_starve != MAX_STARVE);
`endif
            end else begin
                gd = (kd < n_d);
            end
            e.is_d  = gd;
            e.wr    = gd & d_wr_mode;
            e.addr  = gd ? d_addr_of(kd) : i_addr_of(ki);
            e.wdata = gd ? d_wdata_of(kd) : 16'h0000;
            e.err   = (lat == 0);
            e.busy  = (lat == 0) ? TIMEOUT : lat;
            sb.push_back(e);
            if (gd) begin
                if (ki < n_i && m_starve < MAX_STARVE) m_starve++;
                kd++;
            end else begin
                m_starve = 0;
                ki++;
            end
            m_last_d = gd;
        end
    endfunction

    task automatic start(input int n_i, input int n_d);
        i_k         = 0;
        d_k         = 0;
        i_left      = n_i;
        d_left      = n_d;
        bus.i_addr  = i_addr_of(0);
        bus.d_addr  = d_addr_of(0);
        bus.d_wdata = d_wdata_of(0);
        bus.d_wr    = d_wr_mode;
        bus.i_req   = (n_i > 0);
        bus.d_req   = (n_d > 0);
        plan(n_i, n_d);
    endtask

    task automatic monitor();
        exp_t e;
        if (bus.i_done || bus.d_done) begin
            chk("done_excl", bus.i_done & bus.d_done, 64'd0);
            chk("done_after_busy", prev_en, 64'd1);
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("owner_is_d", bus.d_done, e.is_d);
                chk("bus_err", bus.bus_err, e.err);
                chk("busy_len", busy_len, e.busy);
                if (e.is_d) begin
                    if (!e.err && !e.wr) exp_d_rd = mem_val(e.addr);
                    chk("d_rdata", bus.d_rdata, exp_d_rd);
                end else begin
                    if (!e.err) exp_i_rd = mem_val(e.addr);
                    chk("i_rdata", bus.i_rdata, exp_i_rd);
                end
            end
            if (bus.i_done) begin
                i_k++;
                i_left--;
                if (i_left > 0) bus.i_addr = i_addr_of(i_k);
                else bus.i_req = 1'b0;
            end
            if (bus.d_done) begin
                d_k++;
                d_left--;
                if (d_left > 0) begin
                    bus.d_addr  = d_addr_of(d_k);
                    bus.d_wdata = d_wdata_of(d_k);
                end else begin
                    bus.d_req = 1'b0;
                end
            end
        end
        if (bus.mem_en) begin
            if (!prev_en) busy_len = 0;
            busy_len++;
            if (sb.size() > 0) begin
                chk("bus_hold", {bus.mem_addr, bus.mem_wr}, {sb[0].addr, sb[0].wr});
                if (sb[0].wr) chk("bus_wdata", bus.mem_wdata, sb[0].wdata);
            end else begin
                chk("unexpected_en", 64'd1, 64'd0);
            end
        end
        prev_en = bus.mem_en;
    endtask

    // Memory responds after lat BUSY cycles (lat=0: never); noise drives mem_ready while idle
    task automatic memory();
        if (bus.mem_en) begin
            bus.mem_ready = (lat != 0 && busy_len == lat);
            bus.mem_rdata = bus.mem_ready ? mem_val(bus.mem_addr) : 16'hDEAD;
        end else begin
            bus.mem_ready = noise;
            bus.mem_rdata = 16'hF00D;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        memory();
    endtask

    task automatic drain(input int budget);
        int c;
        c = 0;
        while ((sb.size() != 0 || bus.i_req || bus.d_req) && c < budget) begin
            step();
            c++;
        end
        chk("drain", sb.size(), 64'd0);
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.i_req     = 1'b0;
        bus.d_req     = 1'b0;
        bus.d_wr      = 1'b0;
        bus.i_addr    = 16'h0000;
        bus.d_addr    = 16'h0000;
        bus.d_wdata   = 16'h0000;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'h0000;
        lat           = 1;
        noise         = 1'b0;
        m_starve      = 0;
        m_last_d      = 1'b0;
        exp_i_rd      = 16'h0000;
        exp_d_rd      = 16'h0000;
        prev_en       = 1'b0;
        busy_len      = 0;

        // Reset held with both requests pending, then first contention goes to data
        i_base    = 16'h0040;
        d_base    = 16'h0300;
        w_base    = 16'h0000;
        d_wr_mode = 1'b0;
        start(1, 1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_ctrl", {bus.mem_en, bus.mem_wr, bus.i_done, bus.d_done, bus.bus_err}, 64'd0);
            chk("rst_bus", {bus.mem_addr, bus.mem_wdata}, 64'd0);
            chk("rst_rdata", {bus.i_rdata, bus.d_rdata}, 64'd0);
        end
        rst = 1'b0;
        step();
        chk("first_en", bus.mem_en, 64'd1);
        drain(50);

        // Single fetch with a one-cycle memory
        i_base = 16'h0010;
        lat    = 1;
        start(1, 0);
        drain(50);

        // Store with a three-cycle memory
        d_base    = 16'h0200;
        w_base    = 16'h0155;
        d_wr_mode = 1'b1;
        lat       = 3;
        start(0, 1);
        drain(50);

        // Continuous contention, with mem_ready toggling outside BUSY
        i_base    = 16'h1000;
        d_base    = 16'h2000;
        d_wr_mode = 1'b0;
        lat       = 1;
        noise     = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        start(5, 5);
`else
        start(2, 8);
`endif
        drain(200);
        noise = 1'b0;

        // Memory never answers: abort after TIMEOUT BUSY cycles
        i_base = 16'h0020;
        lat    = 0;
        start(1, 0);
        drain(300);
        step();
        chk("idle_after_err", {bus.mem_en, bus.i_done, bus.d_done, bus.bus_err}, 64'd0);

        // Reset during the second BUSY cycle, then a fresh fetch
        d_base    = 16'h0400;
        d_wr_mode = 1'b0;
        lat       = 0;
        start(0, 1);
        for (int c = 0; c < 10 && !bus.mem_en; c++) step();
        chk("rst_busy_seen", bus.mem_en, 64'd1);
        step();
        rst       = 1'b1;
        bus.d_req = 1'b0;
        d_left    = 0;
        sb.delete();
        step();
        chk("rst_en_drop", bus.mem_en, 64'd0);
        rst      = 1'b0;
        m_starve = 0;
        m_last_d = 1'b0;
        exp_i_rd = 16'h0000;
        exp_d_rd = 16'h0000;
        for (int c = 0; c < 4; c++) step();
        chk("rst_rdata_clr", {bus.i_rdata, bus.d_rdata}, 64'd0);
        i_base = 16'h0050;
        lat    = 2;
        start(1, 0);
        drain(50);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
